// File: rtl/if_fetch_buf.sv
// if_fetch_buf: in-order fetch slot ring between PC register, instruction memory and decode
module if_fetch_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              pc_hold_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [INST_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // a redirect right after fresh grants can leave more than DEPTH stale responses in flight
  localparam int OW = PW + 3;
  logic [ADDR_W-1:0] slot_pc [DEPTH];
  logic [INST_W-1:0] slot_inst [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0] alloc, fill, head;
  logic [CW-1:0] used, pend;
  logic [OW-1:0] discard, outstanding;
  logic run, grant, pop, rsp_ok, rsp_keep;
  assign imem_req_o  = run && !flush_i && used < CW'(DEPTH);
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_hold_o   = !flush_i && !grant;
  assign id_valid_o  = run && used != '0 && filled[head] && !flush_i;
  assign id_inst_o   = slot_inst[head];
  assign id_pc_o     = slot_pc[head];
  assign pop         = id_valid_o && id_ready_i;
  assign outstanding = discard + OW'(pend);
  assign rsp_ok      = imem_rvalid_i && outstanding != '0;
  assign rsp_keep    = rsp_ok && discard == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      filled  <= '0;
      alloc   <= '0;
      fill    <= '0;
      head    <= '0;
      used    <= '0;
      pend    <= '0;
      discard <= '0;
    end else begin
      run <= 1'b1;
      if (flush_i) begin
        filled  <= '0;
        used    <= '0;
        pend    <= '0;
        fill    <= alloc;
        head    <= alloc;
        discard <= outstanding - OW'(rsp_ok);
      end else begin
        if (grant) begin
          filled[alloc] <= 1'b0;
          alloc         <= alloc + 1'b1;
        end
        if (rsp_keep) begin
          filled[fill] <= 1'b1;
          fill         <= fill + 1'b1;
        end
        if (rsp_ok && discard != '0) discard <= discard - 1'b1;
        if (pop) head <= head + 1'b1;
        used <= used + CW'(grant) - CW'(pop);
        pend <= pend + CW'(grant) - CW'(rsp_keep);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (grant) slot_pc[alloc] <= pc_i;
    if (rsp_keep && !flush_i) slot_inst[fill] <= imem_rdata_i;
  end
endmodule
